// File: rtl/store_align_buffer.sv
// Store align buffer: formats SB/SH/SW into big-endian byte lanes and queues them (2 entries) toward data memory.
// Latency: 1 cycle from accept to mem_valid. Backpressure: st_ready = !full, held off only by occupancy, never by mem_ready.
// Optional MISALIGN_TRAP_EN: misaligned SH/SW are accepted, dropped and flagged on a 1-cycle misalign pulse.
module store_align_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        empty,
    output logic        full
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

    entry_t     ent_q [2];
    entry_t     new_ent;
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;
    logic       accept;
    logic       entry_ok;
    logic       push;
    logic       pop;

    // Lane 0 of the address offset is the most significant byte (big-endian).
    always_comb begin
        new_ent       = '0;
        new_ent.waddr = st_addr[31:2];
        case (st_size)
            SZ_BYTE: begin
                new_ent.be    = 4'b1000 >> st_addr[1:0];
                new_ent.wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                new_ent.be    = st_addr[1] ? 4'b0011 : 4'b1100;
                new_ent.wdata = {2{st_data[15:0]}};
            end
            SZ_WORD: begin
                new_ent.be    = 4'b1111;
                new_ent.wdata = st_data;
            end
            default: new_ent = '0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((st_size == SZ_HALF) && st_addr[0]) ||
                        ((st_size == SZ_WORD) && (st_addr[1:0] != 2'b00));
    assign entry_ok   = (st_size != 2'b11) && !misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign <= 1'b0;
        else     misalign <= accept && misaligned;
    end
`else
    assign entry_ok = (st_size != 2'b11);
`endif

    assign full      = (cnt == 2'd2);
    assign empty     = (cnt == 2'd0);
    assign st_ready  = !full;
    assign mem_valid = !empty;
    assign accept    = st_valid && st_ready;
    assign push      = accept && entry_ok;
    assign pop       = mem_valid && mem_ready;

    assign head      = ent_q[rd_ptr];
    assign mem_addr  = {head.waddr, 2'b00};
    assign mem_wdata = head.wdata;
    assign mem_be    = head.be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt      <= 2'd0;
        end else begin
            if (push) begin
                ent_q[wr_ptr] <= new_ent;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer: lane formatting table plus full/bypass/reset/misalign sequences.
module tb_store_align_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        empty;
    logic        full;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_pass = 0;
    int n_total = 0;

    store_align_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_size   (st_size),
        .st_data   (st_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .empty     (empty),
        .full      (full)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign  (misalign)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_size  = s;
        st_data  = d;
    endtask

    initial begin
        vecs[0] = '{32'h0000_1002, 2'b00, 32'h0000_00AB, 32'h0000_1000, 4'b0010, 32'hABAB_ABAB};
        vecs[1] = '{32'h0000_1000, 2'b00, 32'h1234_5678, 32'h0000_1000, 4'b1000, 32'h7878_7878};
        vecs[2] = '{32'h0000_1003, 2'b00, 32'h0000_00CD, 32'h0000_1000, 4'b0001, 32'hCDCD_CDCD};
        vecs[3] = '{32'h0000_2002, 2'b01, 32'h1234_BEEF, 32'h0000_2000, 4'b0011, 32'hBEEF_BEEF};
        vecs[4] = '{32'h0000_2000, 2'b01, 32'hAAAA_5555, 32'h0000_2000, 4'b1100, 32'h5555_5555};
        vecs[5] = '{32'h0000_0010, 2'b10, 32'hDEAD_BEEF, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF};

        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0; mem_ready = 1'b0;
        #12;
        check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_empty",     {31'b0, empty},     32'd1);
        check("rst_full",      {31'b0, full},      32'd0);
        check("rst_st_ready",  {31'b0, st_ready},  32'd1);
        check("rst_mem_addr",  mem_addr,           32'd0);
        check("rst_mem_wdata", mem_wdata,          32'd0);
        check("rst_mem_be",    {28'b0, mem_be},    32'd0);
`ifdef MISALIGN_TRAP_EN
        check("rst_misalign",  {31'b0, misalign},  32'd0);
`endif
        rst = 1'b0;
        tick();

        // Lane formatting table: push into empty buffer, inspect head, then retire it.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].addr, vecs[i].size, vecs[i].data);
            tick();
            st_valid = 1'b0;
            check($sformatf("v%0d_mem_valid", i), {31'b0, mem_valid}, 32'd1);
            check($sformatf("v%0d_mem_addr", i),  mem_addr,  vecs[i].exp_addr);
            check($sformatf("v%0d_mem_be", i),    {28'b0, mem_be}, {28'b0, vecs[i].exp_be});
            check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            check($sformatf("v%0d_empty_after", i), {31'b0, empty}, 32'd1);
        end

        // Reserved size: handshake completes but nothing is queued.
        drive(32'h0000_3000, 2'b11, 32'h1111_1111);
        check("rsv_st_ready", {31'b0, st_ready}, 32'd1);
        tick();
        st_valid = 1'b0;
        check("rsv_empty", {31'b0, empty}, 32'd1);
        check("rsv_mem_valid", {31'b0, mem_valid}, 32'd0);

        // Fill to 2 with memory stalled; third request must be refused.
        drive(32'h0000_0100, 2'b10, 32'hAAAA_0001);
        tick();
        check("fill1_full", {31'b0, full}, 32'd0);
        drive(32'h0000_0200, 2'b10, 32'hBBBB_0002);
        tick();
        check("fill2_full", {31'b0, full}, 32'd1);
        check("fill2_st_ready", {31'b0, st_ready}, 32'd0);
        drive(32'h0000_0300, 2'b10, 32'hCCCC_0003);
        tick();
        st_valid = 1'b0;
        check("stall_head_addr", mem_addr, 32'h0000_0100);
        check("stall_head_data", mem_wdata, 32'hAAAA_0001);
        mem_ready = 1'b1;
        tick();
        check("drain1_addr", mem_addr, 32'h0000_0200);
        check("drain1_data", mem_wdata, 32'hBBBB_0002);
        check("drain1_full", {31'b0, full}, 32'd0);
        tick();
        mem_ready = 1'b0;
        check("drain2_empty", {31'b0, empty}, 32'd1);

        // Push and pop on the same edge at count 1.
        drive(32'h0000_0400, 2'b10, 32'h0000_0044);
        tick();
        drive(32'h0000_0500, 2'b10, 32'h0000_0055);
        mem_ready = 1'b1;
        tick();
        st_valid = 1'b0;
        mem_ready = 1'b0;
        check("pp_mem_valid", {31'b0, mem_valid}, 32'd1);
        check("pp_full", {31'b0, full}, 32'd0);
        check("pp_head_addr", mem_addr, 32'h0000_0500);
        check("pp_head_data", mem_wdata, 32'h0000_0055);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("pp_empty", {31'b0, empty}, 32'd1);

        // Asynchronous reset while full.
        drive(32'h0000_0600, 2'b00, 32'h0000_0011);
        tick();
        drive(32'h0000_0700, 2'b00, 32'h0000_0022);
        tick();
        st_valid = 1'b0;
        check("pre_rst_full", {31'b0, full}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("arst_empty", {31'b0, empty}, 32'd1);
        check("arst_mem_be", {28'b0, mem_be}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_empty", {31'b0, empty}, 32'd1);

        // Misaligned word store at 0x6.
        drive(32'h0000_0006, 2'b10, 32'h0102_0304);
        tick();
        st_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        check("mis_pulse", {31'b0, misalign}, 32'd1);
        check("mis_empty", {31'b0, empty}, 32'd1);
        tick();
        check("mis_pulse_end", {31'b0, misalign}, 32'd0);
        check("mis_empty2", {31'b0, empty}, 32'd1);
`else
        check("mis_mem_valid", {31'b0, mem_valid}, 32'd1);
        check("mis_mem_addr", mem_addr, 32'h0000_0004);
        check("mis_mem_be", {28'b0, mem_be}, 32'h0000_000F);
        check("mis_mem_wdata", mem_wdata, 32'h0102_0304);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        drive(32'h0000_2003, 2'b01, 32'h0000_CAFE);
        tick();
        st_valid = 1'b0;
        check("mish_mem_be", {28'b0, mem_be}, 32'h0000_0003);
        check("mish_mem_addr", mem_addr, 32'h0000_2000);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/store_align_buffer.md
STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

Interface
REQ-001 SHALL have no parameters; the buffer depth SHALL be fixed at 2 entries.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 st_valid  input  1  a store request from the memory stage is present.
REQ-005 st_ready  output  1  the buffer can accept a request this cycle.
REQ-006 st_addr  input  32  byte address of the store.
REQ-007 st_size  input  2  store size: 00 = byte (SB), 01 = halfword (SH), 10 = word (SW), 11 = reserved.
REQ-008 st_data  input  32  source register value; the store data is taken from its low bits.
REQ-009 mem_valid  output  1  the head entry is presented to the data memory.
REQ-010 mem_ready  input  1  the data memory accepts the head entry.
REQ-011 mem_addr  output  32  word-aligned address; bits [1:0] are always 00.
REQ-012 mem_wdata  output  32  data replicated or placed into the addressed byte lanes.
REQ-013 mem_be  output  4  byte enables; bit 3 = lane bits [31:24].
REQ-014 empty  output  1  the buffer holds 0 entries.
REQ-015 full  output  1  the buffer holds 2 entries.
REQ-016 misalign  output  1  exists only when MISALIGN_TRAP_EN is defined (REQ-034).

Function
REQ-017 A request SHALL be accepted when st_valid and st_ready are both high on a rising edge.
REQ-018 st_ready SHALL equal not full; there SHALL be no combinational path from mem_ready to st_ready.
REQ-019 The head entry SHALL be retired when mem_valid and mem_ready are both high on a rising edge.
REQ-020 mem_valid SHALL equal not empty; mem_addr, mem_wdata and mem_be SHALL come from the head entry and be registered outputs.
REQ-021 Latency SHALL be 1 cycle: a store accepted at edge N into an empty buffer SHALL drive mem_valid after edge N.
REQ-022 Byte lanes SHALL be big-endian: address offset 00 selects lane bits [31:24], and offset 11 selects lane bits [7:0].
REQ-023 Byte stores SHALL produce mem_be = 1000 >> addr[1:0] and mem_wdata = {4{st_data[7:0]}}.
REQ-024 Halfword stores SHALL produce mem_be = 1100 when addr[1] = 0, else 0011, with mem_wdata = {2{st_data[15:0]}}.
REQ-025 Word stores SHALL produce mem_be = 1111 with mem_wdata = st_data.
REQ-026 A request with st_size = 11 SHALL be accepted (handshake completes) and then dropped: no entry is written and the count does not change.
REQ-027 Entries SHALL be stored in a 2-entry FIFO with a 1-bit write pointer, a 1-bit read pointer and a 2-bit count; the pointers wrap modulo 2.
REQ-028 When a push and a pop occur on the same edge, the count SHALL be unchanged; this SHALL be legal at count 1.
REQ-029 At count 2 only a pop is possible; at count 0 only a push is possible.
REQ-030 Head outputs SHALL hold stable while mem_valid is high and mem_ready is low.

Reset
REQ-031 While rst is asserted, the following SHALL hold asynchronously:
- count = 0 and both pointers = 0;
- mem_valid = 0, empty = 1, full = 0, st_ready = 1;
- mem_addr = 0, mem_wdata = 0, mem_be = 0000;
- misalign = 0 (when present).
REQ-032 A reset asserted mid-operation SHALL discard all buffered entries, with no partial write to memory.

Configuration
REQ-033 Without MISALIGN_TRAP_EN, misaligned address bits SHALL be ignored: a halfword store ignores addr[0], and a word store ignores addr[1:0]. The store then proceeds normally.
REQ-034 With MISALIGN_TRAP_EN defined, each misaligned store (SH with addr[0] = 1, or SW with addr[1:0] != 00) SHALL be accepted and dropped. misalign SHALL pulse high for exactly 1 cycle after the accepting edge, and the count SHALL be unchanged.

Verification
REQ-035 SB: addr = 0x00001002, data = 0x000000AB -> next cycle mem_addr = 0x00001000, mem_be = 0010, mem_wdata = 0xABABABAB.
REQ-036 SH: addr = 0x00002002, data = 0x1234BEEF -> mem_be = 0011, mem_wdata = 0xBEEFBEEF; SW: addr = 0x00000010, data = 0xDEADBEEF -> mem_be = 1111.
REQ-037 Two pushes with mem_ready = 0 -> full = 1 and st_ready = 0; a third st_valid is not accepted. mem_ready = 1 for 2 cycles -> entries retire in order and empty = 1.
REQ-038 At count 1, a simultaneous push and pop -> count stays 1, and the head advances to the new entry on the next cycle.
REQ-039 Assert rst while count = 2 -> mem_valid = 0 and empty = 1 immediately, with no clock edge required.
REQ-040 SW at addr 0x00000006: with MISALIGN_TRAP_EN -> misalign pulses 1 cycle and empty stays 1; without it -> mem_addr = 0x00000004 and mem_be = 1111.
